// File: rtl/fifo_wr_arb.sv
// Packet-atomic round-robin write arbiter in front of a shared show-ahead FIFO.
// Latency: one cycle from requester accept to FIFO write; one idle cycle between packets.
// Backpressure: packets are admitted only with worst-case room; fifo_full stalls the granted requester.
module fifo_wr_arb #(
  parameter int NREQ   = 4,
  parameter int DW     = 256,
  parameter int AW     = 9,
  parameter int DEPTH  = 512,
  parameter int MAXPKT = 16,
  parameter int IW     = 2
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_eop,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        fifo_data,
  output logic                 fifo_wrreq,
  input  logic [AW-1:0]        fifo_usedw,
  input  logic                 fifo_full,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 pkt_err
);

  // Word counter saturates one past MAXPKT so an overlong packet never wraps back to "legal".
  localparam int            CW        = $clog2(MAXPKT + 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAXPKT);
  localparam logic [CW-1:0] CNT_SAT   = CW'(MAXPKT + 1);
  localparam logic [AW:0]   SPACE_LIM = (AW + 1)'(DEPTH - MAXPKT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic            wrreq_q;
  logic [DW-1:0]   data_q;
  logic            err_q;

  logic [AW:0]     fill;
  logic            space_ok;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            sel_valid;
  logic            sel_eop;
  logic [DW-1:0]   sel_data;
  logic            accept;
  logic [CW-1:0]   cnt_inc;

  // The write issued last cycle is not yet reflected in usedw, so count it here.
  assign fill     = {1'b0, fifo_usedw} + {{AW{1'b0}}, wrreq_q};
  assign space_ok = (fill <= SPACE_LIM);

  assign sel_valid = req_valid[grant_q];
  assign sel_eop   = req_eop[grant_q];
  assign sel_data  = req_data[grant_q*DW +: DW];
  assign accept    = (state_q == ST_XFER) && sel_valid && !fifo_full;
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // Round-robin pick: lowest valid index above last_q first, then wrap to the lowest at or below it.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && req_valid[i] && (IW'(i) > last_q)) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && req_valid[i] && (IW'(i) <= last_q)) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end

  // Only the granted requester sees ready, and only while the FIFO is not full.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_XFER) && !fifo_full) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // Arbitration FSM with registered FIFO write port, grant and sticky error.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      // Abort: the word accepted this cycle is dropped; last_q keeps fairness across the abort.
      state_q <= ST_IDLE;
      wrreq_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wrreq_q <= accept;
      if (accept) begin
        data_q <= sel_data;
      end
      // Writing into a full FIFO means someone upstream broke the space contract.
      if (wrreq_q && fifo_full) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_vld && space_ok) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            // Overlong packets are flagged but still carried through to their eop.
            if (cnt_inc > CNT_MAX) begin
              err_q <= 1'b1;
            end
            if (sel_eop) begin
              last_q  <= grant_q;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == ST_XFER);
  assign pkt_err    = err_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus randomized packet mixes.
// Expected FIFO stream and grant order come from a packet-level round-robin model.
// Per-cycle write latency, ready gating and pkt_err are checked against simple rules.
module tb_fifo_wr_arb;
  localparam int NREQ = 4, DW = 256, AW = 9, DEPTH = 512, MAXPKT = 16, IW = 2;
  typedef logic [DW-1:0] word_t;

  logic              clock = 1'b0;
  logic              aclr_n = 1'b1;
  logic              flush = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_eop = '0;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     fifo_data;
  logic              fifo_wrreq;
  logic [AW-1:0]     fifo_usedw = '0;
  logic              fifo_full = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              pkt_err;

  always #5 clock = ~clock;

  fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH), .MAXPKT(MAXPKT), .IW(IW)) dut (
    .clock(clock), .aclr_n(aclr_n), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_eop(req_eop), .req_ready(req_ready),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy), .pkt_err(pkt_err)
  );

  // Requester word queues (driven) and model copies (packet lengths + words).
  word_t wq[NREQ][$];
  bit    eq[NREQ][$];
  word_t mw[NREQ][$];
  int    plen[NREQ][$];
  word_t got[$], expq[$];
  int    gq[$], eg[$];

  int    rr_last;
  bit    exp_wr, exp_err, prev_busy, rnd_full;
  word_t exp_dat;
  int    wcnt, cyc, busy_cyc, first_b, last_b;
  int    n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input word_t obs, input word_t expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (wq[i].size() != 0);
      req_eop[i]   = (wq[i].size() != 0) ? eq[i][0] : 1'b0;
      req_data[i*DW +: DW] = (wq[i].size() != 0) ? wq[i][0] : '0;
    end
  endtask

  task automatic load_pkt(input int r, input int len);
    word_t v;
    for (int w = 0; w < len; w++) begin
      for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom();
      wq[r].push_back(v);
      eq[r].push_back(w == len - 1);
      mw[r].push_back(v);
    end
    plen[r].push_back(len);
    present();
  endtask

  // Packet-level reference: whole packets, round-robin over requesters with pending packets.
  task automatic expect_rr();
    bit any;
    int r, len;
    do begin
      any = 1'b0;
      for (int k = 1; k <= NREQ && !any; k++) begin
        r = (rr_last + k) % NREQ;
        if (plen[r].size() != 0) begin
          len = plen[r].pop_front();
          any = 1'b1;
          eg.push_back(r);
          rr_last = r;
          for (int w = 0; w < len; w++) expq.push_back(mw[r].pop_front());
        end
      end
    end while (any);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (wq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample/check at negedge, update model, then drive new inputs #1 after posedge.
  task automatic step();
    logic [NREQ-1:0] acc_vec;
    int r;
    bit nerr;
    @(negedge clock);
    cyc++;
    chk("wrreq", fifo_wrreq, exp_wr);
    if (exp_wr) chk("wdata", fifo_data, exp_dat);
    chk("pkt_err", pkt_err, exp_err);
    chk("ready_onehot", ($countones(req_ready) <= 1), 1);
    if (fifo_full) chk("ready_when_full", req_ready, 0);
    if (fifo_wrreq === 1'b1) got.push_back(fifo_data);
    if (busy === 1'b1) begin
      busy_cyc++;
      if (first_b < 0) first_b = cyc;
      last_b = cyc;
      if (!prev_busy) gq.push_back(int'(grant_id));
    end
    prev_busy = (busy === 1'b1);
    acc_vec = req_valid & req_ready;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (acc_vec[i]) r = i;
    nerr = exp_err | (fifo_full & exp_wr);
    if (acc_vec != 0) begin
      wcnt++;
      if (wcnt > MAXPKT) nerr = 1'b1;
      if (req_eop[r]) wcnt = 0;
    end
    exp_wr  = (acc_vec != 0);
    exp_dat = req_data[r*DW +: DW];
    if (flush) begin
      exp_wr = 1'b0;
      nerr   = 1'b0;
      wcnt   = 0;
    end
    exp_err = nerr;
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_vec[i]) begin
        void'(wq[i].pop_front());
        void'(eq[i].pop_front());
      end
    end
    if (rnd_full) fifo_full = ($urandom_range(0, 7) == 0);
    present();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(all_empty() && busy === 1'b0 && fifo_wrreq === 1'b0) && n < budget);
    chk({tag, "_timeout"}, (n < budget), 1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nwords"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) chk({tag, "_word"}, got[i], expq[i]);
    chk({tag, "_ngrants"}, gq.size(), eg.size());
    for (int i = 0; i < gq.size() && i < eg.size(); i++) chk({tag, "_grant"}, gq[i], eg[i]);
    got.delete(); expq.delete(); gq.delete(); eg.delete();
  endtask

  task automatic do_reset();
    flush = 1'b0; fifo_full = 1'b0; fifo_usedw = '0; rnd_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      wq[i].delete(); eq[i].delete(); mw[i].delete(); plen[i].delete();
    end
    got.delete(); expq.delete(); gq.delete(); eg.delete();
    present();
    aclr_n = 1'b1;
    #1 aclr_n = 1'b0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", pkt_err, 0);
    exp_wr = 1'b0; exp_err = 1'b0; wcnt = 0; rr_last = NREQ - 1; prev_busy = 1'b0;
    busy_cyc = 0; first_b = -1; last_b = -1;
    @(negedge clock);
    aclr_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    word_t w1, w2;
    cyc = 0;

    // Requester 2 alone, 4-word packet into an empty FIFO.
    do_reset();
    load_pkt(2, 4);
    expect_rr();
    run_idle("t1", 100);
    chk("t1_busy_cycles", busy_cyc, 4);
    check_stream("t1");

    // All four requesters back to back with 2-word packets; requester 0 has two.
    do_reset();
    load_pkt(0, 2); load_pkt(0, 2); load_pkt(1, 2); load_pkt(2, 2); load_pkt(3, 2);
    expect_rr();
    run_idle("t2", 200);
    chk("t2_busy_cycles", busy_cyc, 10);
    chk("t2_busy_span", last_b - first_b + 1, 14);
    check_stream("t2");

    // Space threshold: 496 blocks admission, 495 admits.
    do_reset();
    fifo_usedw = 9'd496;
    load_pkt(0, 2);
    expect_rr();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_no_grant", busy, 0);
      chk("t3_no_ready", req_ready, 0);
    end
    fifo_usedw = 9'd495;
    step();
    chk("t3_granted", busy, 1);
    chk("t3_grant_id", grant_id, 0);
    run_idle("t3", 100);
    check_stream("t3");
    fifo_usedw = '0;

    // Overlong 17-word packet: fully written, sticky error until flush.
    load_pkt(1, 17);
    expect_rr();
    run_idle("t4", 200);
    check_stream("t4");
    for (int i = 0; i < 3; i++) step();
    chk("t4_err_sticky", pkt_err, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_err_cleared", pkt_err, 0);

    // fifo_full held for three cycles in the middle of an 8-word packet.
    load_pkt(0, 8);
    expect_rr();
    for (int i = 0; i < 3; i++) step();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) step();
    fifo_full = 1'b0;
    run_idle("t5", 200);
    check_stream("t5");

    // Flush on word 3 of an 8-word packet; fairness pointer must not advance.
    do_reset();
    load_pkt(0, 8);
    load_pkt(1, 2);
    w1 = wq[0][0];
    w2 = wq[0][1];
    mw[0].delete(); plen[0].delete();
    expq.push_back(w1); expq.push_back(w2); eg.push_back(0);
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_idle_after_flush", busy, 0);
    chk("t6_err_after_flush", pkt_err, 0);
    wq[0].delete(); eq[0].delete();
    load_pkt(0, 2);
    expect_rr();
    run_idle("t6", 200);
    check_stream("t6");

    // Randomized packet mixes with random fifo_full.
    do_reset();
    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < NREQ; r++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) load_pkt(r, $urandom_range(1, MAXPKT + 2));
      end
      expect_rr();
      rnd_full = 1'b1;
      run_idle("rnd", 3000);
      rnd_full = 1'b0;
      fifo_full = 1'b0;
      step();
      check_stream("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Packet-atomic round-robin write arbiter that lets NREQ streaming requesters share one single-clock show-ahead FIFO (DEPTH words, DW wide).
- Sits in front of the shared FIFO and is the only agent driving its data/wrreq.
- Admits a packet only when the FIFO has room for a worst-case packet, so no packet ever stalls mid-transfer on a full FIFO in normal operation.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 256, data width in bits
- AW, 9, width of FIFO usedw
- DEPTH, 512, FIFO depth in words
- MAXPKT, 16, maximum legal packet length in words (>=1, < DEPTH-2)
- IW, 2, grant index width, equal to clog2(NREQ)

Ports:
- clock  in  1  single clock
- aclr_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns the block to IDLE
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*DW  per-requester data; requester i uses bits [i*DW +: DW]
- req_eop  in  NREQ  last word of packet
- req_ready  out  NREQ  per-requester accept
- fifo_data  out  DW  write data to FIFO
- fifo_wrreq  out  1  write strobe to FIFO
- fifo_usedw  in  AW  FIFO fill level
- fifo_full  in  1  FIFO full
- grant_id  out  IW  index of current or last granted requester
- busy  out  1  high while in XFER
- pkt_err  out  1  sticky; packet exceeded MAXPKT or write attempted while full

Behaviour:
- Reset (aclr_n=0, asynchronous): req_ready=0, fifo_wrreq=0, fifo_data=0, grant_id=0, busy=0, pkt_err=0, state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), word count=0.
- Space check: space_ok = ({1'b0,fifo_usedw} + fifo_wrreq) <= DEPTH-MAXPKT-1, evaluated at AW+1 bits. The fifo_wrreq term covers the write still in flight.
- State IDLE:
  - req_ready=0.
  - If any req_valid and space_ok, pick the first requester with req_valid set, searching round-robin from last_grant+1 modulo NREQ.
  - Register the pick into grant_id, clear the word count, and go to XFER.
  - Otherwise stay in IDLE.
- State XFER:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0. req_ready is combinational from state, grant_id and fifo_full.
  - On accept (req_valid & req_ready at grant_id), next cycle fifo_data = the accepted word and fifo_wrreq=1; otherwise fifo_wrreq=0. Latency is exactly 1 cycle from accept to write.
  - The word count increments on every accept.
  - Accept with req_eop: last_grant<=grant_id and go to IDLE. This leaves one bubble cycle between packets.
  - Accept that makes the count exceed MAXPKT without eop: set pkt_err and keep transferring until eop (no truncation).
  - Requesters must hold valid/data stable while not accepted.
- busy=1 exactly while in XFER.
- grant_id holds its value in IDLE.
- flush=1, synchronous, highest priority after reset:
  - state<=IDLE, fifo_wrreq<=0 on the next edge; a word accepted in the flush cycle is dropped.
  - last_grant is unchanged; pkt_err is cleared.
  - A flushed partial packet is the requester's responsibility.
- Simultaneous valid from all requesters: strict round-robin with no starvation. Each requester waits at most NREQ-1 packets.
- If fifo_full is seen while fifo_wrreq is high (external misuse), set pkt_err; the write is still issued.
- Single-word packet (valid+eop on the first accept): IDLE, XFER, IDLE in 3 cycles.

Test Plan:
- Reset, then requester 2 sends a 4-word packet with the FIFO empty -> grant_id=2, fifo_wrreq high for 4 consecutive cycles starting 1 cycle after the first accept, data in order, busy falls the cycle after eop.
- All 4 requesters hold 2-word packets continuously -> grant order 0,1,2,3,0; exactly one idle cycle between packets; no data interleaving.
- fifo_usedw=496 (>495 limit, DEPTH=512, MAXPKT=16), requester 0 valid -> no grant, req_ready=0; drop usedw to 495 -> grant next cycle.
- Requester 1 sends 17 words with eop on word 17 -> all 17 written, pkt_err=1 and sticky until flush or reset.
- fifo_full pulsed for 3 cycles mid-packet -> req_ready[grant_id]=0 during those cycles, no word lost or duplicated, packet completes.
- flush asserted on word 3 of an 8-word packet -> word 3 not written, state IDLE next cycle, pkt_err=0; the next grant goes to last_grant+1.
